pip_query_arbiter: RTL
======================

# pip_query_arbiter

Shares one point-in-polygon engine (PIP top: `Enable`, `x_check`/`y_check`, `x_in`/`y_in`, `finished`, `Result`) between NREQ query requesters. Grants requesters round-robin, streams the POINTS polygon vertices from a vertex store into the engine, waits for `finished`, and returns the tagged result. Sits between the query clients and the PIP instance, one level above it.

## Interface

- WIDTH, 16, coordinate and result width.
- POINTS, 5, polygon vertex count. Must be ≥3.
- NREQ, 4, number of requesters. Must be ≥2.
- ID_W, $clog2(NREQ), requester-ID width.
- VA_W, $clog2(POINTS), vertex address width.
- TIMEOUT, 1024, WAIT-state watchdog limit in cycles. Used only with PIP_TIMEOUT_EN.

Ports:

- clk, in, 1, single clock. All logic is on the rising edge.
- rstN, in, 1. Reset is synchronous and active-low.
- req_valid, in, NREQ, per-requester query valid. The requester holds it until granted.
- req_ready, out, NREQ, one-hot grant pulse.
- req_x, in, NREQ*WIDTH, packed query x. Slice i is requester i.
- req_y, in, NREQ*WIDTH, packed query y.
- vtx_addr, out, VA_W, vertex store read address. Read latency is exactly 1 cycle.
- vtx_x, in, WIDTH, vertex x data.
- vtx_y, in, WIDTH, vertex y data.
- pip_enable, out, 1, drives engine `Enable`.
- pip_x_check, out, WIDTH, drives engine `x_check`.
- pip_y_check, out, WIDTH, drives engine `y_check`.
- pip_x_in, out, WIDTH, drives engine `x_in`.
- pip_y_in, out, WIDTH, drives engine `y_in`.
- pip_finished, in, 1, engine `finished`.
- pip_result, in, WIDTH, engine `Result`. Valid in the cycle pip_finished=1.
- rsp_valid, out, 1, one-cycle response pulse.
- rsp_id, out, ID_W, index of the requester that owns the response.
- rsp_result, out, WIDTH, registered engine result.
- rsp_err, out, 1, timeout flag. Tied to 0 without PIP_TIMEOUT_EN.
- busy, out, 1, high in every state except IDLE.

## Operation

FSM states: IDLE, GRANT, LOAD, WAIT, DONE.

- **IDLE**
  - If any req_valid is set, pick the winner by round-robin. The search starts at rr_ptr.
  - Go to GRANT.
- **GRANT** (1 cycle)
  - req_ready[winner]=1.
  - Latch req_x/req_y slices into the check registers and latch the winner ID.
  - vtx_addr=0.
  - Set rr_ptr = winner+1, modulo NREQ.
- **LOAD** (exactly POINTS cycles)
  - pip_enable=1.
  - pip_x_in/pip_y_in = vtx_x/vtx_y, which is the data for the address issued the previous cycle.
  - vtx_addr increments each cycle. It holds at POINTS-1 and never exceeds it.
  - The vertex counter ends at POINTS-1, then go to WAIT.
- **WAIT**
  - pip_enable stays 1. pip_x_in/pip_y_in hold the last vertex.
  - On pip_finished=1: register pip_result and go to DONE.
- **DONE** (1 cycle)
  - rsp_valid=1, with rsp_id and rsp_result.
  - pip_enable=0. This gives the engine its mandatory ≥1-cycle low gap between jobs.
  - Go to IDLE.

Rules:

- pip_x_check/pip_y_check stay constant from the first LOAD cycle through DONE.
- pip_finished is ignored outside WAIT. If it arrives during the last LOAD cycle, it is ignored and WAIT waits for the next pulse; the engine contract forbids this case.
- Requests arriving mid-job wait. Exactly one job is outstanding at a time.
- Synchronous reset in any state:
  - Next edge: IDLE, rr_ptr=0, counters cleared, the in-flight job is discarded and no response is emitted.
  - A requester that was granted before reset does not re-request automatically.

## Timing

- Reset values: req_ready=0, vtx_addr=0, pip_enable=0, all pip_* data=0, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_err=0, busy=0.
- With request seen in IDLE at cycle T:
  - GRANT is T+1.
  - LOAD is T+2 .. T+1+POINTS.
  - WAIT starts at T+2+POINTS.
  - If pip_finished arrives at cycle F, rsp_valid is at F+1.
- Minimum request-to-response time is POINTS+4 cycles, assuming finished in the first WAIT cycle.
- Back-to-back jobs: the next GRANT comes 2 cycles after DONE at the earliest (IDLE, then GRANT).
- Round-robin is fair: a continuously asserted req_valid is granted within NREQ jobs.

## Configuration

- PIP_TIMEOUT_EN defined:
  - A WAIT cycle counter runs. When it reaches TIMEOUT, go to DONE with rsp_err=1 and rsp_result=0.
  - If finished arrives in the same cycle the limit is reached, the normal result wins and rsp_err=0.
- Undefined: no counter, rsp_err is constant 0, and WAIT is unbounded.

## Structure

- pip_pkg holds:
  - state_t enum (IDLE, GRANT, LOAD, WAIT, DONE).
  - Default constants for WIDTH, POINTS and NREQ.
- Sub-module rr_arbiter (parameter NREQ):
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant and encoded index.
  - Purely combinational. The pointer register lives in pip_query_arbiter.

## Test plan

- **Single request.** Req 2 asserted with x=7, y=3, POINTS=5; engine model returns finished 3 cycles after WAIT entry with Result=1.
  - Expect req_ready[2] pulse, vtx_addr sequence 0,1,2,3,4.
  - Expect rsp_valid with rsp_id=2, rsp_result=1, 12 cycles after the request.
- **Round-robin.** All 4 requests held.
  - Expect grant order 0,1,2,3,0.
  - Expect pip_enable low for exactly 1 cycle (DONE) between jobs.
- **Vertex alignment.** Vertex store holds (10,0),(20,0),(20,20),(10,20),(15,30).
  - Expect pip_x_in/pip_y_in to match each entry in successive LOAD cycles, with check values stable.
- **Mid-job reset.** rstN=0 for one cycle during LOAD.
  - Expect IDLE, all outputs zero, no rsp_valid.
  - Expect the next request to be served starting with requester 0.
- **Timeout (PIP_TIMEOUT_EN, TIMEOUT=8).** Engine never finishes.
  - Expect rsp_valid with rsp_err=1 and rsp_result=0 in the 9th cycle after WAIT entry.
  - A second variant with finished in the same cycle the counter hits 8 expects rsp_err=0.

Source files
------------

// File: rtl/pip_pkg.sv
// -----------------------------------------------------------------------------
// pip_pkg
// Shared types and default sizes for the point-in-polygon query arbiter.
//   state_t          : arbiter FSM state encoding
//   PIP_*_DEF        : default WIDTH / POINTS / NREQ values
// No ports.
// -----------------------------------------------------------------------------
package pip_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANT,
      LOAD,
      WAIT,
      DONE
   } state_t;

   localparam int PIP_WIDTH_DEF  = 16;
   localparam int PIP_POINTS_DEF = 5;
   localparam int PIP_NREQ_DEF   = 4;

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search starts at rr_ptr and wraps; the
// pointer register itself lives in the parent.
// Ports:
//   req       in  NREQ  request vector
//   rr_ptr    in  ID_W  highest-priority index for this pick
//   grant     out NREQ  one-hot winner (all zero when no request)
//   grant_idx out ID_W  encoded winner (zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter #(
   parameter int NREQ = 4,
   parameter int ID_W = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] rr_ptr,
   output logic [NREQ-1:0] grant,
   output logic [ID_W-1:0] grant_idx
);

   always_comb begin
      logic            found;
      logic [ID_W-1:0] cand;
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = ID_W'((int'(rr_ptr) + i) % NREQ);
         if (!found && req[cand]) begin
            found       = 1'b1;
            grant[cand] = 1'b1;
            grant_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/pip_query_arbiter.sv
// -----------------------------------------------------------------------------
// pip_query_arbiter
// Shares one point-in-polygon engine between NREQ query clients. Grants
// round-robin, streams the polygon vertices from the vertex store into the
// engine, waits for finished and returns the tagged result.
// Optional feature macro: PIP_TIMEOUT_EN (adds the TIMEOUT parameter and a
// WAIT-state watchdog that drives rsp_err; without it rsp_err is constant 0).
// Ports:
//   clk, rstN                      clock, synchronous active-low reset
//   req_valid/req_ready            per-client request / one-hot grant pulse
//   req_x, req_y                   packed query points, slice i = client i
//   vtx_addr / vtx_x, vtx_y        vertex store port, 1-cycle read latency
//   pip_enable, pip_x_check, pip_y_check, pip_x_in, pip_y_in   to engine
//   pip_finished, pip_result       from engine
//   rsp_valid, rsp_id, rsp_result, rsp_err   response pulse and payload
//   busy                           high in every state except IDLE
// -----------------------------------------------------------------------------
// state | meaning
// IDLE  | no job; pick a winner when any request is valid
// GRANT | pulse req_ready, latch query point, vertex address 0 issued
// LOAD  | POINTS cycles streaming vertices into the engine
// WAIT  | engine running; wait for finished (or watchdog expiry)
// DONE  | one-cycle response; engine enable low between jobs
// -----------------------------------------------------------------------------
module pip_query_arbiter
   import pip_pkg::*;
#(
   parameter int WIDTH  = PIP_WIDTH_DEF,
   parameter int POINTS = PIP_POINTS_DEF,
   parameter int NREQ   = PIP_NREQ_DEF,
   parameter int ID_W   = $clog2(NREQ),
   parameter int VA_W   = $clog2(POINTS)
`ifdef PIP_TIMEOUT_EN
   , parameter int TIMEOUT = 1024
`endif
) (
   input  logic                  clk,
   input  logic                  rstN,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [NREQ*WIDTH-1:0] req_x,
   input  logic [NREQ*WIDTH-1:0] req_y,
   output logic [VA_W-1:0]       vtx_addr,
   input  logic [WIDTH-1:0]      vtx_x,
   input  logic [WIDTH-1:0]      vtx_y,
   output logic                  pip_enable,
   output logic [WIDTH-1:0]      pip_x_check,
   output logic [WIDTH-1:0]      pip_y_check,
   output logic [WIDTH-1:0]      pip_x_in,
   output logic [WIDTH-1:0]      pip_y_in,
   input  logic                  pip_finished,
   input  logic [WIDTH-1:0]      pip_result,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [WIDTH-1:0]      rsp_result,
   output logic                  rsp_err,
   output logic                  busy
);

   localparam logic [VA_W-1:0] LAST_ADDR = VA_W'(POINTS - 1);

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, win_id_q, arb_idx;
   logic [NREQ-1:0]   win_oh_q, arb_oh;
   logic [VA_W-1:0]   addr_q, load_cnt_q;
   logic [WIDTH-1:0]  x_chk_q, y_chk_q, x_in_q, y_in_q, result_q;
   logic              load_last, wd_expired;

   rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_rr (
      .req       (req_valid),
      .rr_ptr    (rr_ptr_q),
      .grant     (arb_oh),
      .grant_idx (arb_idx)
   );

   // load_cnt is a down-counter of remaining LOAD cycles; zero marks the last.
   assign load_last = (load_cnt_q == '0);

`ifdef PIP_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT + 1);
   logic [WD_W-1:0] wd_cnt_q;
   logic            err_q;
   // Reloaded every LOAD cycle, so it holds TIMEOUT-1 on WAIT entry and hits
   // zero in the TIMEOUT-th WAIT cycle.
   assign wd_expired = (wd_cnt_q == '0);
   assign rsp_err    = err_q;
`else
   assign wd_expired = 1'b0;
   assign rsp_err    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstN) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (|req_valid) state_d = GRANT;
         GRANT:   state_d = LOAD;
         LOAD:    if (load_last) state_d = WAIT;
         WAIT:    if (pip_finished || wd_expired) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstN) begin
         rr_ptr_q   <= '0;
         win_id_q   <= '0;
         win_oh_q   <= '0;
         addr_q     <= '0;
         load_cnt_q <= '0;
         x_chk_q    <= '0;
         y_chk_q    <= '0;
         x_in_q     <= '0;
         y_in_q     <= '0;
         result_q   <= '0;
`ifdef PIP_TIMEOUT_EN
         wd_cnt_q   <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|req_valid) begin
                  win_id_q <= arb_idx;
                  win_oh_q <= arb_oh;
               end
            end
            GRANT: begin
               x_chk_q    <= req_x[win_id_q*WIDTH +: WIDTH];
               y_chk_q    <= req_y[win_id_q*WIDTH +: WIDTH];
               rr_ptr_q   <= (win_id_q == ID_W'(NREQ - 1)) ? '0 : win_id_q + 1'b1;
               load_cnt_q <= LAST_ADDR;
               addr_q     <= VA_W'(1);
            end
            LOAD: begin
               x_in_q <= vtx_x;
               y_in_q <= vtx_y;
               if (addr_q != LAST_ADDR) addr_q <= addr_q + 1'b1;
               if (!load_last) load_cnt_q <= load_cnt_q - 1'b1;
`ifdef PIP_TIMEOUT_EN
               wd_cnt_q <= WD_W'(TIMEOUT - 1);
`endif
            end
            WAIT: begin
               if (pip_finished) begin
                  result_q <= pip_result;
`ifdef PIP_TIMEOUT_EN
                  err_q    <= 1'b0;
               end else if (wd_expired) begin
                  result_q <= '0;
                  err_q    <= 1'b1;
               end else begin
                  wd_cnt_q <= wd_cnt_q - 1'b1;
`endif
               end
            end
            DONE: addr_q <= '0;
            default: ;
         endcase
      end
   end

   assign busy        = (state_q != IDLE);
   assign req_ready   = (state_q == GRANT) ? win_oh_q : '0;
   assign vtx_addr    = addr_q;
   assign pip_enable  = (state_q == LOAD) || (state_q == WAIT);
   assign pip_x_check = x_chk_q;
   assign pip_y_check = y_chk_q;
   // During LOAD the store data goes straight through; afterwards the last
   // vertex is held from the capture register.
   assign pip_x_in    = (state_q == LOAD) ? vtx_x : x_in_q;
   assign pip_y_in    = (state_q == LOAD) ? vtx_y : y_in_q;
   assign rsp_valid   = (state_q == DONE);
   assign rsp_id      = win_id_q;
   assign rsp_result  = result_q;

endmodule
